// File: rtl/key_mixing.sv
// RC5-style key mixing engine. Walks the S and L tables in place through
// 3*max(T,C) iterations. Each iteration is a fixed six-cycle sequence:
// fetch, load, mix A, write S, mix B, write L.
module key_mixing #(
   parameter  int T  = 16,
   parameter  int W  = 32,
   parameter  int C  = 4,
   localparam int TL = (T > 1) ? $clog2(T) : 1,
   localparam int CL = (C > 1) ? $clog2(C) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          iStart,
   input  logic [W-1:0]  iS_data,
   input  logic [W-1:0]  iL_data,
   output logic [TL-1:0] oS_address,
   output logic [W-1:0]  oS_data,
   output logic          oS_we,
   output logic [CL-1:0] oL_address,
   output logic [W-1:0]  oL_data,
   output logic          oL_we,
   output logic          oDone
);

   localparam int N  = 3 * ((T > C) ? T : C);
   localparam int KW = $clog2(N + 1);
   localparam int RW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [2:0] {
      IDLE, FETCH, LOAD, MIX_A, WRITE_S, MIX_B, WRITE_L, DONE
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d, b_q, b_d;
   logic [W-1:0]  sreg_q, sreg_d, lreg_q, lreg_d;
   logic [TL-1:0] i_q, i_d;
   logic [CL-1:0] j_q, j_d;
   logic [KW-1:0] k_q, k_d;
   logic          s_we_q, s_we_d, l_we_q, l_we_d, done_q, done_d;
   logic [W-1:0]  sum_ab;

   // Rotate left; a zero amount returns x unchanged because x >> W is zero.
   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [RW-1:0] r);
      return (x << r) | (x >> (W - int'(r)));
   endfunction

   assign sum_ab = a_q + b_q;

   // State register; reset forces IDLE without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic: start is honoured only while idle or finished.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (iStart) state_d = FETCH;
         FETCH:      state_d = LOAD;
         LOAD:       state_d = MIX_A;
         MIX_A:      state_d = WRITE_S;
         WRITE_S:    state_d = MIX_B;
         MIX_B:      state_d = WRITE_L;
         WRITE_L:    state_d = (k_q == KW'(N - 1)) ? DONE : FETCH;
         default:    state_d = IDLE;
      endcase
   end

   // Datapath next-state: mixing arithmetic, table capture and index advance.
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      sreg_d = sreg_q;
      lreg_d = lreg_q;
      i_d    = i_q;
      j_d    = j_q;
      k_d    = k_q;
      case (state_q)
         IDLE, DONE: begin
            if (iStart) begin
               a_d = '0;
               b_d = '0;
               i_d = '0;
               j_d = '0;
               k_d = '0;
            end
         end
         LOAD: begin
            sreg_d = iS_data;
            lreg_d = iL_data;
         end
         MIX_A:   a_d = rotl(sreg_q + sum_ab, RW'(3));
         MIX_B:   b_d = rotl(lreg_q + sum_ab, sum_ab[RW-1:0]);
         WRITE_L: begin
            i_d = (i_q == TL'(T - 1)) ? '0 : i_q + TL'(1);
            j_d = (j_q == CL'(C - 1)) ? '0 : j_q + CL'(1);
            k_d = k_q + KW'(1);
         end
         default: ;
      endcase
   end

   // Output decode from the upcoming state so strobes are registered.
   always_comb begin
      s_we_d = (state_d == WRITE_S);
      l_we_d = (state_d == WRITE_L);
      done_d = (state_d == DONE);
   end

   // Datapath and output registers; everything clears asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q    <= '0;
         b_q    <= '0;
         sreg_q <= '0;
         lreg_q <= '0;
         i_q    <= '0;
         j_q    <= '0;
         k_q    <= '0;
         s_we_q <= 1'b0;
         l_we_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         a_q    <= a_d;
         b_q    <= b_d;
         sreg_q <= sreg_d;
         lreg_q <= lreg_d;
         i_q    <= i_d;
         j_q    <= j_d;
         k_q    <= k_d;
         s_we_q <= s_we_d;
         l_we_q <= l_we_d;
         done_q <= done_d;
      end
   end

   // Addresses are the index registers themselves, which only move after WRITE_L.
   assign oS_address = i_q;
   assign oL_address = j_q;
   assign oS_data    = a_q;
   assign oL_data    = b_q;
   assign oS_we      = s_we_q;
   assign oL_we      = l_we_q;
   assign oDone      = done_q;

endmodule

// File: doc/key_mixing.md
KEY_MIXING -- requirements
Module: key_mixing

Interface
REQ-001 Parameter T, default 16: number of words in the S table; address width TL = max(1, clog2(T)).
REQ-002 Parameter W, default 32: word width in bits; power of two.
REQ-003 Parameter C, default 4: number of words in the L key table; address width CL = max(1, clog2(C)).
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 iStart  input  1  start request, sampled only in IDLE and DONE.
REQ-007 iS_data  input  W  S table read data, valid the cycle after oS_address is presented.
REQ-008 iL_data  input  W  L table read data, same timing as iS_data.
REQ-009 oS_address  output  TL  S table address.
REQ-010 oS_data  output  W  S table write data.
REQ-011 oS_we  output  1  S table write enable.
REQ-012 oL_address  output  CL  L table address.
REQ-013 oL_data  output  W  L table write data.
REQ-014 oL_we  output  1  L table write enable.
REQ-015 oDone  output  1  mixing complete, held until restart or reset.

Function
REQ-016 The block SHALL consume the S table filled by the S initialisation stage and perform RC5-style key mixing in place on S and L.
REQ-017 The block SHALL run N = 3*max(T,C) iterations; for default parameters N = 48.
REQ-018 The block SHALL hold internal registers A, B (W bits), i (TL bits), j (CL bits) and iteration counter k.
REQ-019 The block SHALL use states IDLE, FETCH, LOAD, MIX_A, WRITE_S, MIX_B, WRITE_L and DONE; all outputs are registered.
REQ-020 IDLE: on iStart=1, clear A, B, i, j and k, then go to FETCH; otherwise remain in IDLE.
REQ-021 FETCH (1 cycle): drive oS_address=i and oL_address=j, with oS_we=oL_we=0.
REQ-022 LOAD (1 cycle): capture iS_data into Sreg and iL_data into Lreg.
REQ-023 MIX_A: set A <= rotl((Sreg + A + B) mod 2^W, 3).
REQ-024 WRITE_S: for exactly 1 cycle, drive oS_data=A and oS_we=1, with oS_address still equal to i.
REQ-025 MIX_B: set B <= rotl((Lreg + A + B) mod 2^W, (A + B) mod W), using the low log2(W) bits of the sum.
REQ-026 WRITE_L: for exactly 1 cycle, drive oL_data=B and oL_we=1, with oL_address still equal to j.
REQ-027 After WRITE_L, set i <= (i+1) mod T, j <= (j+1) mod C and k <= k+1.
REQ-028 After WRITE_L, go to DONE if k+1 == N; otherwise go to FETCH.
REQ-029 Each iteration SHALL take exactly 6 cycles; oDone SHALL rise 6*N cycles after the edge that samples iStart in IDLE (288 cycles for default parameters).
REQ-030 In DONE, oDone=1 and both write enables are 0; iStart=1 restarts exactly as from IDLE and deasserts oDone on the next edge.
REQ-031 iStart SHALL be ignored in all states other than IDLE and DONE.
REQ-032 Index wrap: i and j SHALL wrap independently, and the block SHALL never address at or beyond T or C.
REQ-033 All additions SHALL be modulo 2^W; a rotation amount of 0 SHALL pass the value through unchanged.

Reset
REQ-034 While rst=0, the block SHALL immediately enter IDLE, and all outputs, A, B, i, j, k, Sreg and Lreg SHALL be 0, regardless of clk.
REQ-035 Reset asserted mid-iteration SHALL drop oS_we and oL_we asynchronously; no partial write may complete afterward.
REQ-036 After rst returns to 1, the block SHALL remain in IDLE until iStart is sampled high.

Verification
REQ-037 Single-step check: T=16, C=4, S[0]=0xB7E15163, L all 0, pulse iStart -> first S write 0xBF0A8B1D to address 0, first L write 0xB7E15163 to address 0.
REQ-038 Full run check: T=16, C=4, S preloaded as P=0xB7E15163 / Q=0x9E3779B9 chain, key 0 -> final S and L tables match the C reference model; oDone rises exactly 288 cycles after start.
REQ-039 Wrap check: T=4, C=6 -> N=18; write addresses follow i=0,1,2,3,0,... and j=0..5,0,...; no address out of range; oDone rises at cycle 108.
REQ-040 Reset mid-run: deassert rst during WRITE_S at iteration 5 -> oS_we=0 immediately, all outputs 0, state IDLE; a fresh start gives a result identical to an uninterrupted run on freshly preloaded tables.
REQ-041 Restart and ignore: pulse iStart mid-run -> no effect on the run; pulse iStart in DONE -> oDone=0 on the next edge and a new 6*N-cycle run begins.
